// File: rtl/pc_sequencer_pkg.sv
// Shared constants and types for the fetch sequencer: MIPS opcode/funct values,
// ALU op encodings, FSM states and the ID/EX control bundle.
package pc_sequencer_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  typedef struct packed {
    logic       regDst;
    logic       regWrite;
    logic       aluSrc;
    logic       jump;
    logic       branch;
    logic [2:0] aluOp;
  } ctrl_t;

  localparam ctrl_t CTRL_NONE = '0;

  // Unknown R-type functs fall back to ADD so the datapath stays well defined.
  function automatic logic [2:0] functToAluOp(input logic [5:0] funct);
    case (funct)
      FN_ADD:  return ALU_ADD;
      FN_SUB:  return ALU_SUB;
      FN_AND:  return ALU_AND;
      FN_OR:   return ALU_OR;
      FN_SLT:  return ALU_SLT;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/pc_sequencer_ctrl_decode.sv
// Combinational decode of a fetched word's opcode/funct into the control bundle
// that the sequencer registers as the ID/EX stage.
module pc_sequencer_ctrl_decode
  import pc_sequencer_pkg::*;
(
  input  logic [5:0] i_opcode,
  input  logic [5:0] i_funct,
  output ctrl_t      o_ctrl
);

  always_comb begin
    o_ctrl = CTRL_NONE;
    case (i_opcode)
      OP_RTYPE: begin
        o_ctrl.regDst   = 1'b1;
        o_ctrl.regWrite = 1'b1;
        o_ctrl.aluSrc   = 1'b0;
        o_ctrl.aluOp    = functToAluOp(i_funct);
      end
      OP_J: begin
        o_ctrl.aluSrc = 1'b1;
        o_ctrl.jump   = 1'b1;
        o_ctrl.aluOp  = ALU_ADD;
      end
      OP_BEQ: begin
        o_ctrl.branch = 1'b1;
        o_ctrl.aluOp  = ALU_SUB;
      end
      OP_SW: begin
        o_ctrl.aluSrc = 1'b1;
        o_ctrl.aluOp  = ALU_ADD;
      end
      default: begin
        o_ctrl.regWrite = 1'b1;
        o_ctrl.aluSrc   = 1'b1;
        o_ctrl.aluOp    = ALU_ADD;
      end
    endcase
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch sequencer: owns the PC (entry, +4, jump, branch redirect, stall), the
// IDLE/RUN/HALT FSM, the issued-instruction counter and the ID/EX control register.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] ENTRY_PC  = XLEN'(128),
  parameter int              MAX_INSNS = 0,
  parameter int              CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [XLEN-1:0]  ins,
  input  logic             stall,
  input  logic             branch_taken,
  input  logic [XLEN-1:0]  branch_target,
  output logic [XLEN-1:0]  pc,
  output logic [XLEN-1:0]  pc_plus4,
  output logic             ctrl_valid,
  output logic             reg_dst,
  output logic             reg_write,
  output logic             alu_src,
  output logic             jump,
  output logic             branch,
  output logic [2:0]       alu_op,
  output logic [CNT_W-1:0] issued_cnt,
  output logic             busy,
  output logic             halted
);

  localparam bit              HAS_LIMIT = (MAX_INSNS != 0);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_INSNS - 1);

  state_t           r_state;
  state_t           w_nextState;
  logic [XLEN-1:0]  r_pc;
  logic [XLEN-1:0]  w_nextPc;
  logic [XLEN-1:0]  w_pcPlus4;
  logic [XLEN-1:0]  w_jumpPc;
  logic [CNT_W-1:0] r_cnt;
  ctrl_t            r_ctrl;
  ctrl_t            w_decCtrl;
  logic             r_ctrlValid;
  logic             w_issue;
  logic             w_limitHit;
  logic             w_restart;

  pc_sequencer_ctrl_decode u_decode (
    .i_opcode (ins[31:26]),
    .i_funct  (ins[5:0]),
    .o_ctrl   (w_decCtrl)
  );

  assign w_pcPlus4  = r_pc + XLEN'(4);
  assign w_jumpPc   = {w_pcPlus4[XLEN-1:28], ins[25:0], 2'b00};
  assign w_issue    = (r_state == ST_RUN) && !stall && !branch_taken;
  assign w_limitHit = HAS_LIMIT && w_issue && (r_cnt == LAST_CNT);

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_nextState;
  end

  // The limiting instruction still issues on the edge that moves us to HALT.
  always_comb begin
    w_nextState = r_state;
    w_nextPc    = r_pc;
    w_restart   = 1'b0;
    case (r_state)
      ST_IDLE, ST_HALT: begin
        if (start) begin
          w_nextState = ST_RUN;
          w_nextPc    = ENTRY_PC;
          w_restart   = 1'b1;
        end
      end
      ST_RUN: begin
        if (w_limitHit) w_nextState = ST_HALT;
        if (branch_taken)        w_nextPc = branch_target;
        else if (stall)          w_nextPc = r_pc;
        else if (w_decCtrl.jump) w_nextPc = w_jumpPc;
        else                     w_nextPc = w_pcPlus4;
      end
      default: w_nextState = ST_IDLE;
    endcase
  end

  // Bubbles and squashes clear only ctrl_valid; the control fields hold their last value.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pc        <= ENTRY_PC;
      r_cnt       <= '0;
      r_ctrl      <= CTRL_NONE;
      r_ctrlValid <= 1'b0;
    end else begin
      r_pc        <= w_nextPc;
      r_ctrlValid <= w_issue;
      if (w_issue) r_ctrl <= w_decCtrl;
      if (w_restart)                   r_cnt <= '0;
      else if (w_issue && r_cnt != '1) r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign pc         = r_pc;
  assign pc_plus4   = w_pcPlus4;
  assign ctrl_valid = r_ctrlValid;
  assign reg_dst    = r_ctrl.regDst;
  assign reg_write  = r_ctrl.regWrite;
  assign alu_src    = r_ctrl.aluSrc;
  assign jump       = r_ctrl.jump;
  assign branch     = r_ctrl.branch;
  assign alu_op     = r_ctrl.aluOp;
  assign issued_cnt = r_cnt;
  assign busy       = (r_state == ST_RUN);
  assign halted     = (r_state == ST_HALT);

endmodule
